key_sched_iter: RTL and testbench

Iterative AES-128 key expansion stage that feeds the round pipeline. It accepts one 128-bit cipher key over a valid/ready handshake. It then emits the initial key followed by the ten expanded round keys, one key every two clock cycles, which matches the two-cycle round cadence of the round stages downstream. The single round-key output is registered and consumed by the round and final-round stages.

---
 rtl/key_sched_iter.sv | 141 ++++++++++++++
 tb/tb_key_sched_iter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_iter.sv
// Iterative AES-128 key expansion: emits key 0..10, one key every two cycles.
// Includes the registered four-byte S-box used by the expansion step.
module S4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] sub;

    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++)
            sub[8*i +: 8] = sbox(din[8*i +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout <= '0;
        else     dout <= sub;
    end

endmodule

module key_sched_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] MIX  = 2'd2;

    logic [1:0]   state;
    logic [127:0] key_q;
    logic [7:0]   rcon;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [31:0]  w0n;
    logic [31:0]  w1n;
    logic [31:0]  w2n;
    logic [31:0]  w3n;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

    S4 u_s4 (
        .clk  (clk),
        .rst  (~reset),
        .din  (key_q[31:0]),
        .dout (sub)
    );

    always_comb begin
        t         = {sub[23:0], sub[31:24]} ^ {rcon, 24'h0};
        w0n       = key_q[127:96] ^ t;
        w1n       = key_q[95:64] ^ w0n;
        w2n       = key_q[63:32] ^ w1n;
        w3n       = key_q[31:0] ^ w2n;
        next_key  = {w0n, w1n, w2n, w3n};
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            key_q     <= '0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
            rk_out    <= '0;
            rk_idx    <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        state     <= SUB;
                        key_q     <= key_in;
                        rk_out    <= key_in;
                        rk_idx    <= '0;
                        rk_valid  <= 1'b1;
                        rcon      <= 8'h01;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end else begin
                        // Entering IDLE keeps busy high through the last pulse.
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                SUB: state <= MIX;
                MIX: begin
                    key_q    <= next_key;
                    rk_out   <= next_key;
                    rk_idx   <= rk_idx + 4'd1;
                    rk_valid <= 1'b1;
                    rcon     <= rcon_next;
                    state    <= (rk_idx < 4'(NR - 1)) ? SUB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_iter.sv
// Bench for key_sched_iter: cycle-level schedule model plus FIPS-197 vectors.
// The model derives S-box and expansion independently of the RTL datapath.
module tb_key_sched_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         busy;

    key_sched_iter #(.NR(10)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0] sbox_t [256];
    logic [7:0] rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Walk the multiplicative group with generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                  ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] expand_key(logic [127:0] k, int n);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]],
                       sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rcon_t[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Model: cycles since acceptance; odd counts 1..21 carry key (cnt-1)/2.
    int           m_cnt;
    logic         m_ready;
    logic         m_busy;
    logic         m_valid;
    logic [3:0]   m_idx;
    logic [127:0] m_rk;
    logic [127:0] m_keys [11];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_idx   = '0;
            m_rk    = '0;
        end else begin
            if (m_cnt == 0 && m_ready && key_valid) begin
                for (int n = 0; n < 11; n++) m_keys[n] = expand_key(key_in, n);
                m_cnt   = 1;
                m_ready = 1'b0;
            end else if (m_cnt != 0) begin
                m_cnt++;
                if (m_cnt == 22) begin
                    m_cnt   = 0;
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
            end
            m_busy  = (m_cnt != 0);
            m_valid = m_cnt[0];
            if (m_valid) begin
                m_idx = 4'((m_cnt - 1) / 2);
                m_rk  = m_keys[m_idx];
            end
        end
    end

    logic chk_en = 1'b0;
    int   pulses = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("key_ready", 128'(key_ready), 128'(m_ready));
            check("busy", 128'(busy), 128'(m_busy));
            check("rk_valid", 128'(rk_valid), 128'(m_valid));
            check("rk_idx", 128'(rk_idx), 128'(m_idx));
            check("rk_out", rk_out, m_rk);
            if (rk_valid) pulses++;
        end
    end

    task automatic wait_idx(int n);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (rk_valid && rk_idx == 4'(n)) found = 1'b1;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idx%0d: no pulse within budget", n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_key(logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_ready"}, 128'(key_ready), 128'(0));
        check({tag, "_rk_out"}, rk_out, 128'(0));
        check({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
        check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        build_sbox();
        check("model_sbox00", 128'(sbox_t[8'h00]), 128'h63);
        check("model_sbox01", 128'(sbox_t[8'h01]), 128'h7c);
        check("model_sbox53", 128'(sbox_t[8'h53]), 128'hed);
        check("model_fips_k1", expand_key(FIPS_KEY, 1), FIPS_K1);
        check("model_fips_k10", expand_key(FIPS_KEY, 10), FIPS_K10);
        check("model_zero_k10", expand_key(128'h0, 10), ZERO_K10);

        repeat (2) step();
        check_zero_outputs("reset");
        chk_en = 1'b1;

        // Key offered in the release cycle must wait one extra edge.
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        rst_n     = 1'b1;
        step();
        check("ready_after_release", 128'(key_ready), 128'(1));
        step();
        key_valid = 1'b0;
        pulses = 0;
        wait_idx(1);
        check("fips_k1", rk_out, FIPS_K1);
        wait_idx(10);
        check("fips_k10", rk_out, FIPS_K10);
        repeat (20) step();
        check("fips_pulses", 128'(pulses), 128'(11));
        check("hold_idx", 128'(rk_idx), 128'(10));
        check("hold_rk", rk_out, FIPS_K10);

        run_key(128'h0);
        wait_idx(1);
        check("zero_k1", rk_out, ZERO_K1);
        wait_idx(10);
        check("zero_k10", rk_out, ZERO_K10);
        repeat (3) step();

        // Streamed keys: only the one present at each acceptance is used.
        for (int c = 0; c < 50; c++) begin
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            key_valid = 1'b1;
            step();
        end
        key_valid = 1'b0;
        repeat (25) step();

        run_key({$urandom, $urandom, $urandom, $urandom});
        wait_idx(4);
        step();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_midrst", 128'(key_ready), 128'(1));
        run_key(FIPS_KEY);
        wait_idx(0);
        check("fresh_k0", rk_out, FIPS_KEY);
        wait_idx(1);
        check("fresh_k1", rk_out, FIPS_K1);
        repeat (25) step();

        run_key({$urandom, $urandom, $urandom, $urandom});
        repeat (25) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
